// File: rtl/snn_img_loader_ctrl_if.sv
// Bundle of the loader controller's datapath/handshake signals.
//   slave  : the controller (snn_img_loader_ctrl)
//   master : the surrounding system (UART RX/TX, inference core, input RAM)
// Inputs to the controller : rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy
// Outputs of the controller: ram_addr, ram_d, ram_we, core_start, tx_start,
//                            tx_data, digit, result_vld, overrun
interface snn_img_loader_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] core_addr;
  logic              core_done;
  logic [3:0]        core_digit;
  logic              tx_busy;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_d;
  logic              ram_we;
  logic              core_start;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [3:0]        digit;
  logic              result_vld;
  logic              overrun;

  modport master (
    output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    input  ram_addr, ram_d, ram_we, core_start, tx_start, tx_data, digit,
           result_vld, overrun
  );

  modport slave (
    input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_busy,
    output ram_addr, ram_d, ram_we, core_start, tx_start, tx_data, digit,
           result_vld, overrun
  );
endinterface

// File: rtl/snn_img_loader_ctrl.sv
// Top-level sequencer for the SNN inference core.
// Receives a packed binary image byte-by-byte from the UART receiver, unpacks
// it LSB first (byte k bit j -> address 8k+j) into the 1-bit input-unit RAM,
// pulses the core's start, waits for done, then sends the digit as ASCII.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (aborts to LOAD, partial image lost)
//   bus   : snn_img_loader_ctrl_if.slave (UART RX/TX, core, RAM signals)
module snn_img_loader_ctrl #(
  parameter int unsigned IMG_BITS  = 784,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned NUM_BYTES = 98
) (
  input  logic                 clk,
  input  logic                 rst_n,
  snn_img_loader_ctrl_if.slave bus
);

  // Image ends at whichever limit comes first; they coincide when consistent.
  localparam int unsigned IMG_LEN = (IMG_BITS < NUM_BYTES * 8) ? IMG_BITS : NUM_BYTES * 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_LEN - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_UNPACK,
    S_START,
    S_RUN,
    S_TX
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_bit_cnt;
  logic [2:0]        r_sub;
  logic [7:0]        r_shift;
  logic              r_core_start;
  logic [7:0]        r_tx_data;
  logic [3:0]        r_digit;
  logic              r_result_vld;
  logic              r_overrun;

  logic w_unpack;
  logic w_tx_fire;

  assign w_unpack  = (r_state == S_UNPACK);
  // Fires in the same cycle the transmitter is seen idle so core_done to
  // tx_start is a single cycle.
  assign w_tx_fire = (r_state == S_TX) && !bus.tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_bit_cnt    <= '0;
      r_sub        <= '0;
      r_shift      <= '0;
      r_core_start <= 1'b0;
      r_tx_data    <= 8'h00;
      r_digit      <= '0;
      r_result_vld <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (bus.rx_rdy) begin
            r_shift <= bus.rx_data;
            r_sub   <= '0;
            if (r_bit_cnt == '0) r_overrun <= 1'b0;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (bus.rx_rdy) r_overrun <= 1'b1;
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + ADDR_W'(1);
          r_sub     <= r_sub + 3'd1;
          if (r_sub == 3'd7) begin
            if (r_bit_cnt == LAST_ADDR) begin
              r_state      <= S_START;
              r_core_start <= 1'b1;  // high exactly while in START
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_START: begin
          if (bus.rx_rdy) r_overrun <= 1'b1;
          r_bit_cnt <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (bus.rx_rdy) r_overrun <= 1'b1;
          if (bus.core_done) begin
            r_digit      <= bus.core_digit;
            r_result_vld <= 1'b1;
            // ASCII code prepared here so tx_data is registered when TX fires.
            r_tx_data    <= 8'h30 + {4'h0, bus.core_digit};
            r_state      <= S_TX;
          end
        end
        S_TX: begin
          if (bus.rx_rdy) r_overrun <= 1'b1;
          if (!bus.tx_busy) r_state <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.ram_addr   = (r_state == S_LOAD || w_unpack) ? r_bit_cnt : bus.core_addr;
  assign bus.ram_we     = w_unpack;
  assign bus.ram_d      = w_unpack & r_shift[0];
  assign bus.core_start = r_core_start;
  assign bus.tx_start   = w_tx_fire;
  assign bus.tx_data    = r_tx_data;
  assign bus.digit      = r_digit;
  assign bus.result_vld = r_result_vld;
  assign bus.overrun    = r_overrun;

endmodule

// File: doc/snn_img_loader_ctrl.md
Name: snn_img_loader_ctrl

Overview:
- Top-level sequencer for the SNN inference core.
- Receives a packed 784-bit binary image as 98 bytes from the UART receiver and unpacks it, one bit per cycle, into the 1-bit-wide input-unit RAM.
- Owns the RAM address mux while loading, then pulses the core's start and waits for done.
- Latches the classified digit and sends it as an ASCII character through the UART transmitter; then re-arms for the next image.

Parameters:
- IMG_BITS, 784, number of input units / RAM words.
- ADDR_W, 10, input-unit RAM address width.
- NUM_BYTES, 98, bytes per image (IMG_BITS/8).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_rdy  input  1  one-cycle pulse: rx_data valid
- rx_data  input  8  received byte
- core_addr  input  ADDR_W  input-unit read address driven by the core
- core_done  input  1  one-cycle pulse: inference complete
- core_digit  input  4  classification result, valid with core_done
- tx_busy  input  1  transmitter busy
- ram_addr  output  ADDR_W  input-unit RAM address (muxed)
- ram_d  output  1  input-unit RAM write data
- ram_we  output  1  input-unit RAM write enable
- core_start  output  1  one-cycle start pulse to the core
- tx_start  output  1  one-cycle transmit request
- tx_data  output  8  byte to transmit
- digit  output  4  last result, held
- result_vld  output  1  digit holds a valid result
- overrun  output  1  sticky: byte dropped

Behaviour:
- Reset values:
  - FSM in LOAD; all counters 0.
  - ram_we=0, ram_d=0, core_start=0, tx_start=0.
  - tx_data=8'h00, digit=0, result_vld=0, overrun=0.
- Reset mid-operation aborts immediately to LOAD. Partial images are discarded. The core is not re-started.
- ram_addr mux:
  - LOAD and UNPACK: ram_addr = bit_cnt (bit_cnt is a 10-bit write counter, 0..IMG_BITS-1).
  - All other states: ram_addr = core_addr.
- States:
  - LOAD: wait for a byte.
    - rx_rdy=1: capture rx_data into an 8-bit shift register, clear the 3-bit sub-counter, go to UNPACK.
    - First byte of an image (bit_cnt==0) clears overrun.
  - UNPACK: one bit written per cycle.
    - Each cycle: ram_we=1, ram_d=shift[0]. Then shift right, bit_cnt+1, sub+1.
    - Ordering is LSB first: byte k bit j goes to address 8k+j.
    - After 8 writes, if bit_cnt reached IMG_BITS, go to START; else go to LOAD.
    - rx_rdy during UNPACK: byte dropped, overrun<=1.
  - START: core_start=1 for exactly one cycle; bit_cnt<=0; go to RUN.
  - RUN: wait for core_done.
    - On core_done: digit<=core_digit, result_vld<=1, go to TX.
  - TX: wait for the transmitter.
    - If tx_busy=0: tx_start=1 for one cycle, tx_data=8'h30+digit (ASCII), go to LOAD.
    - Else stay in TX with tx_start=0.
- Latency:
  - Last rx_rdy of an image to core_start: 9 cycles (1 capture + 8 writes).
  - core_done to tx_start: 1 cycle when tx_busy=0.
- rx_rdy outside LOAD/UNPACK (START, RUN, TX): byte dropped, overrun<=1. The host must wait for the result character before sending the next image.
- core_done outside RUN: ignored. digit and result_vld are unchanged.
- result_vld stays 1 until reset. digit holds until the next core_done in RUN.
- bit_cnt never exceeds IMG_BITS-1 on a write. There is no wrap within an image.
- ram_we is never asserted outside UNPACK.

Test Plan:
- Reset check: after reset release, all outputs are at their reset values, and ram_addr follows core_addr=10'h155 only once the FSM leaves LOAD/UNPACK. Driving core_addr in LOAD leaves ram_addr=0.
- Full load: send 98 bytes 8'hA5 spaced 20 cycles apart.
  - Exactly 784 ram_we pulses at addresses 0..783.
  - ram_d pattern per byte is 1,0,1,0,0,1,0,1.
  - A single core_start occurs 9 cycles after the 98th rx_rdy.
- Result path: pulse core_done with core_digit=7 and tx_busy=0 → next cycle tx_start=1, tx_data=8'h37, digit=7, result_vld=1. FSM returns to LOAD.
- Transmitter busy: hold tx_busy=1 for 50 cycles around core_done (digit=3) → tx_start stays 0 throughout, then is asserted one cycle after tx_busy falls, with tx_data=8'h33.
- Overrun:
  - rx_rdy 3 cycles after the previous byte (inside UNPACK) → overrun=1, that byte is not written, and bit_cnt advances by only 8.
  - Next image's first accepted byte clears overrun.
  - rx_rdy during RUN also sets overrun.
- Reset mid-run: assert rst_n=0 after 40 bytes loaded → no core_start. A subsequent full 98-byte load starts again at address 0 and yields exactly one core_start.
